mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-stage access controller. Sits between the ex_mem pipeline register and the mem_wb pipeline register.
- Takes the load/store request held in ex_mem and drives the data-cache request interface until dhit.
- Produces the load data and store-conditional result that mem_wb captures.
- Asserts mem_busy so the hazard unit drops the pipe enables while an access is outstanding.
- Owns the LL/SC link register.

Parameters:
TMO_W, 8, width of the access timeout counter
TMO_MAX, 200, cycles in ACCESS without dhit before the access is abandoned (must be < 2**TMO_W)

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
req_valid  in  1  valid instruction present in MEM (from ex_mem)
ren  in  1  load request
wen  in  1  store request
ll  in  1  instruction is LL (qualifies ren)
sc  in  1  instruction is SC (qualifies wen)
addr  in  32  byte address from ex_mem
store_data  in  32  store data from ex_mem
dhit  in  1  cache completion strobe
dload  in  32  cache read data, valid with dhit
snoop_inv  in  1  coherence invalidate strobe
snoop_addr  in  32  invalidated address
dREN  out  1  cache read request
dWEN  out  1  cache write request
daddr  out  32  cache address
dstore  out  32  cache write data
load_data  out  32  to mem_wb dmemload input
sc_result  out  1  SC outcome (1 = success), to mem_wb
mem_busy  out  1  stall request to hazard unit
done  out  1  one-cycle pulse: access finished this cycle
link_valid  out  1  link register valid
link_addr  out  32  linked address
timeout_err  out  1  sticky: an access timed out

Behaviour:
- Reset (nRST low at a rising edge, including mid-access):
  - state = IDLE.
  - All registered outputs = 0: dREN, dWEN, daddr, dstore, load_data, sc_result, done, link_valid, link_addr, timeout_err.
  - Timeout counter = 0.
  - Any outstanding cache request deasserts on that edge.
- Request decode: acc = req_valid & (ren | wen). ren & wen together is treated as a write (dREN = 0).
- Address compares use addr[31:2] only.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If acc & sc & !(link_valid & addr[31:2]==link_addr[31:2]): SC fails.
    - Next state DONE; sc_result <= 0; link_valid <= 0.
    - No cache request is issued.
  - Else if acc:
    - Next state ACCESS.
    - Latch daddr <= addr, dstore <= store_data, dWEN <= wen, dREN <= ren & !wen.
    - Counter <= 0.
- ACCESS:
  - dREN/dWEN stay asserted; daddr/dstore are stable.
  - On dhit:
    - dREN, dWEN <= 0; next state DONE.
    - If the access is a read: load_data <= dload.
    - If sc: sc_result <= 1 and link_valid <= 0.
    - If ll: link_valid <= 1 and link_addr <= daddr.
    - If a plain store hits link_addr: link_valid <= 0.
  - Without dhit: counter increments.
    - When counter == TMO_MAX-1: timeout_err <= 1, load_data <= 0, sc_result <= 0, request deasserted, next state DONE.
  - Changes on req_valid, ren or wen are ignored while in ACCESS; the latched access always completes.
- DONE:
  - done = 1 for exactly this cycle; mem_busy = 0 so the pipeline advances.
  - Next state is always IDLE. A new request is not examined in DONE, which prevents re-issue of the same instruction.
- mem_busy (combinational) = (IDLE & acc) | ACCESS. It is 0 in DONE.
- Latency:
  - Hit on the first ACCESS cycle: request seen in cycle 0, dREN high in cycle 1, dhit in cycle 1, done in cycle 2.
  - mem_busy is high for cycles 0 and 1.
  - A failed SC: done in cycle 1.
- load_data and sc_result hold their values until the next completing load or SC.
- Snoop:
  - snoop_inv & snoop_addr[31:2]==link_addr[31:2] clears link_valid.
  - If the same cycle also completes an LL to the same word, the snoop wins (link_valid = 0).
  - A snoop during an SC in ACCESS does not abort the SC; the pass/fail decision is taken in IDLE.
- timeout_err clears only on reset.

Test Plan:
- Load, addr=0x100, dhit on the 1st ACCESS cycle with dload=0xDEADBEEF -> dREN=1 for exactly 1 cycle, mem_busy high 2 cycles, done on cycle 2, load_data=0xDEADBEEF.
- Store, addr=0x204, store_data=0x12345678, dhit after 4 wait cycles -> dWEN/daddr/dstore stable for 5 cycles, dREN=0, mem_busy high 6 cycles, then one done pulse.
- LL 0x300 hit, then SC 0x300 hit -> link_valid=1, link_addr=0x300 after LL; sc_result=1 and link_valid=0 after SC. SC 0x304 instead -> no dWEN, sc_result=0, done 1 cycle after request.
- LL 0x400 completing in the same cycle as snoop_inv with snoop_addr=0x402 -> link_valid=0. A following SC 0x400 fails without a cache request.
- Load with dhit never asserted, TMO_MAX=200 -> request deasserts after 200 ACCESS cycles, timeout_err=1 (sticky), load_data=0, done pulses once.
- nRST low for one edge during the 3rd ACCESS cycle of a store -> next cycle dWEN=0, state IDLE, link_valid=0, timeout_err=0. A re-presented request restarts the full sequence.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: drives the D-cache request from ex_mem until dhit, returns load/SC results, owns the LL/SC link.
// Latency: hit on first ACCESS cycle -> done two cycles after the request is seen; a failing SC completes one cycle after.
module mem_access_ctrl #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  input  logic        ren,
  input  logic        wen,
  input  logic        ll,
  input  logic        sc,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        dhit,
  input  logic [31:0] dload,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic [31:0] load_data,
  output logic        sc_result,
  output logic        mem_busy,
  output logic        done,
  output logic        link_valid,
  output logic [31:0] link_addr,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_t           state;
  logic [TMO_W-1:0] cnt;
  logic             ll_q;
  logic             sc_q;

  logic        acc;
  logic        is_sc;
  logic        is_ll;
  logic        sc_fail;
  logic        ll_complete;
  logic [31:0] snoop_target;
  logic        snoop_hit;

  assign acc     = req_valid & (ren | wen);
  assign is_sc   = sc & wen;
  assign is_ll   = ll & ren & ~wen;
  assign sc_fail = acc & is_sc & ~(link_valid & (addr[31:2] == link_addr[31:2]));

  // A snoop against the word an LL is linking this very cycle must still kill the link.
  assign ll_complete  = (state == ACCESS) & dhit & ll_q;
  assign snoop_target = ll_complete ? daddr : link_addr;
  assign snoop_hit    = snoop_inv & (snoop_addr[31:2] == snoop_target[31:2]);

  assign mem_busy = ((state == IDLE) & acc) | (state == ACCESS);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      ll_q        <= 1'b0;
      sc_q        <= 1'b0;
      dREN        <= 1'b0;
      dWEN        <= 1'b0;
      daddr       <= '0;
      dstore      <= '0;
      load_data   <= '0;
      sc_result   <= 1'b0;
      done        <= 1'b0;
      link_valid  <= 1'b0;
      link_addr   <= '0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sc_fail) begin
            state      <= DONE;
            done       <= 1'b1;
            sc_result  <= 1'b0;
            link_valid <= 1'b0;
          end else if (acc) begin
            state  <= ACCESS;
            daddr  <= addr;
            dstore <= store_data;
            dWEN   <= wen;
            dREN   <= ren & ~wen;
            ll_q   <= is_ll;
            sc_q   <= is_sc;
            cnt    <= '0;
          end
        end
        ACCESS: begin
          if (dhit) begin
            state <= DONE;
            done  <= 1'b1;
            dREN  <= 1'b0;
            dWEN  <= 1'b0;
            if (dREN) load_data <= dload;
            if (sc_q) begin
              sc_result  <= 1'b1;
              link_valid <= 1'b0;
            end
            if (ll_q) begin
              link_valid <= 1'b1;
              link_addr  <= daddr;
            end
            if (dWEN && !sc_q && (daddr[31:2] == link_addr[31:2])) link_valid <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            state       <= DONE;
            done        <= 1'b1;
            dREN        <= 1'b0;
            dWEN        <= 1'b0;
            timeout_err <= 1'b1;
            load_data   <= '0;
            sc_result   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (snoop_hit) link_valid <= 1'b0;
    end
  end

endmodule
